// File: rtl/out_decim_fifo_pkg.sv
// Shared widths and helpers for the output decimator + FIFO.
// Holds sample width, depth, pointer/count widths, decim helper.
package out_decim_fifo_pkg;

  localparam int NB_DATA    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int DECIM_W    = 4;

  // A factor of 0 behaves as 1 (push every enabled sample).
  function automatic logic [DECIM_W-1:0] eff_decim(
    input logic [DECIM_W-1:0] d
  );
    return (d == '0) ? DECIM_W'(1) : d;
  endfunction

endpackage

// File: rtl/out_decim_fifo_if.sv
// Sample stream in, FIFO head/status out, for out_decim_fifo.
// master: stimulus/consumer side; slave: the decimator block.
interface out_decim_fifo_if #(
  parameter int NB_DATA    = out_decim_fifo_pkg::NB_DATA,
  parameter int FIFO_DEPTH = out_decim_fifo_pkg::FIFO_DEPTH
);

  logic                        i_enable;
  logic signed [NB_DATA-1:0]   i_data;
  logic [3:0]                  i_decim;
  logic                        i_ready;
  logic                        i_clear_ovf;
  logic signed [NB_DATA-1:0]   o_data;
  logic                        o_valid;
  logic [$clog2(FIFO_DEPTH):0] o_count;
  logic                        o_overflow;

  modport master (
    output i_enable,
    output i_data,
    output i_decim,
    output i_ready,
    output i_clear_ovf,
    input  o_data,
    input  o_valid,
    input  o_count,
    input  o_overflow
  );

  modport slave (
    input  i_enable,
    input  i_data,
    input  i_decim,
    input  i_ready,
    input  i_clear_ovf,
    output o_data,
    output o_valid,
    output o_count,
    output o_overflow
  );

endinterface

// File: rtl/out_decim_fifo_sync_fifo.sv
// First-word fall-through FIFO with a registered head word.
// Ports: push/wr_data in, pop in, rd_data/valid/count/full/empty out.
module sync_fifo #(
  parameter  int NB_DATA    = out_decim_fifo_pkg::NB_DATA,
  parameter  int FIFO_DEPTH = out_decim_fifo_pkg::FIFO_DEPTH,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic signed [NB_DATA-1:0] wr_data,
  output logic signed [NB_DATA-1:0] rd_data,
  output logic                      valid,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      empty
);

  logic signed [NB_DATA-1:0] mem [FIFO_DEPTH];
  logic signed [NB_DATA-1:0] head_nxt;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          rd_nxt;
  logic [CNT_W-1:0]          left;
  logic [CNT_W-1:0]          cnt_nxt;
  logic                      do_push;
  logic                      do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head register is loaded with what the head will be after this
  // edge; when nothing older remains, the incoming word is the head.
  always_comb begin
    rd_nxt   = rd_ptr + PTR_W'(do_pop);
    left     = count - CNT_W'(do_pop);
    cnt_nxt  = left + CNT_W'(do_push);
    head_nxt = '0;
    priority case (1'b1)
      (cnt_nxt == '0): head_nxt = '0;
      (left == '0):    head_nxt = wr_data;
      default:         head_nxt = mem[rd_nxt];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      valid   <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_nxt;
      count   <= cnt_nxt;
      rd_data <= head_nxt;
      valid   <= (cnt_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/out_decim_fifo.sv
// Decimates the FIR output stream and buffers kept samples.
// Ports: clock, i_reset (async, low), bus (slave) with stream/status.
module out_decim_fifo #(
  parameter  int NB_DATA    = out_decim_fifo_pkg::NB_DATA,
  parameter  int FIFO_DEPTH = out_decim_fifo_pkg::FIFO_DEPTH,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             i_reset,
  out_decim_fifo_if.slave  bus
);

  import out_decim_fifo_pkg::*;

  logic [DECIM_W-1:0]        phase;
  logic [DECIM_W-1:0]        d_eff;
  logic                      push;
  logic                      pop;
  logic                      ovf_evt;
  logic                      ovf_q;
  logic signed [NB_DATA-1:0] head;
  logic                      head_vld;
  logic [CNT_W-1:0]          count;
  logic                      full;
  logic                      empty;

  assign d_eff = eff_decim(bus.i_decim);

  // Comparing with >= makes a lowered factor push on the next
  // enabled cycle instead of running the phase to its old limit.
  assign push    = bus.i_enable && (phase >= d_eff - 1'b1);
  assign pop     = bus.i_ready && !empty;
  assign ovf_evt = push && full && !pop;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      phase <= '0;
    end else if (bus.i_enable) begin
      phase <= push ? '0 : phase + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)
      ovf_q <= 1'b0;
    else if (ovf_evt)
      ovf_q <= 1'b1;
    else if (bus.i_clear_ovf)
      ovf_q <= 1'b0;
  end

  sync_fifo #(
    .NB_DATA    (NB_DATA),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (i_reset),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.i_data),
    .rd_data (head),
    .valid   (head_vld),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign bus.o_data     = head;
  assign bus.o_valid    = head_vld;
  assign bus.o_count    = count;
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_out_decim_fifo.sv
// Randomized + directed bench for out_decim_fifo.
// Queue-based model checked every cycle, plus literal checks.
module tb_out_decim_fifo;

  import out_decim_fifo_pkg::*;

  logic clock   = 1'b0;
  logic i_reset = 1'b0;

  always #5 clock = ~clock;

  out_decim_fifo_if bus ();

  out_decim_fifo dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  int q[$];
  int ph  = 0;
  bit ovf = 1'b0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      q.delete();
      ph  = 0;
      ovf = 1'b0;
    end else begin
      int d;
      bit pop_m;
      bit push_m;
      bit evt;
      d      = (bus.i_decim == 4'd0) ? 1 : int'(bus.i_decim);
      pop_m  = (q.size() > 0) && bus.i_ready;
      push_m = bus.i_enable && (ph + 1 >= d);
      if (bus.i_enable)
        ph = push_m ? 0 : ph + 1;
      evt = push_m && (q.size() == FIFO_DEPTH) && !pop_m;
      if (pop_m)
        void'(q.pop_front());
      if (push_m && !evt)
        q.push_back(int'(bus.i_data));
      if (evt)
        ovf = 1'b1;
      else if (bus.i_clear_ovf)
        ovf = 1'b0;
    end
  end

  always @(negedge clock) begin
    check("count", int'(bus.o_count), q.size());
    check("valid", int'(bus.o_valid), int'(q.size() > 0));
    check("data", int'(bus.o_data), (q.size() > 0) ? q[0] : 0);
    check("ovf", int'(bus.o_overflow), int'(ovf));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(bit en, int data, int dec, bit rdy, bit clr);
    bus.i_enable    = en;
    bus.i_data      = data[7:0];
    bus.i_decim     = dec[3:0];
    bus.i_ready     = rdy;
    bus.i_clear_ovf = clr;
  endtask

  task automatic zeros(string tag);
    check({tag, "_cnt0"}, int'(bus.o_count), 0);
    check({tag, "_vld0"}, int'(bus.o_valid), 0);
    check({tag, "_dat0"}, int'(bus.o_data), 0);
    check({tag, "_ovf0"}, int'(bus.o_overflow), 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    #1;
    zeros("rst");
    tick();
    i_reset = 1'b1;
  endtask

  initial begin
    int dec;
    int rmode;
    drive(0, 0, 1, 0, 0);
    tick();
    do_reset();

    for (int i = 0; i < 8; i++) begin
      drive(1, i, 1, 1, 0);
      tick();
      check("d1_data", int'(bus.o_data), i);
      check("d1_cnt", int'(bus.o_count <= 1), 1);
    end
    check("d1_ovf", int'(bus.o_overflow), 0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1, i, 4, 1, 0);
      tick();
      check("d4_vld", int'(bus.o_valid), int'(i % 4 == 3));
      if (i % 4 == 3)
        check("d4_data", int'(bus.o_data), i);
    end

    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 10 + i, 1, 0, 0);
      tick();
    end
    check("full_cnt", int'(bus.o_count), 4);
    check("full_ovf", int'(bus.o_overflow), 1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 1, 0);
      check("drain_data", int'(bus.o_data), 10 + k);
      tick();
    end
    check("drain_vld", int'(bus.o_valid), 0);
    check("ovf_sticky", int'(bus.o_overflow), 1);
    drive(0, 0, 1, 0, 1);
    tick();
    check("ovf_clr", int'(bus.o_overflow), 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 20 + i, 1, 0, 0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1, 24 + k, 1, 1, 0);
      tick();
      check("pp_cnt", int'(bus.o_count), 4);
      check("pp_ovf", int'(bus.o_overflow), 0);
      check("pp_data", int'(bus.o_data), 21 + k);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 1, 0);
      check("pp_order", int'(bus.o_data), 22 + k);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 60 + i, 0, 0, 0);
      tick();
    end
    drive(1, 99, 0, 0, 1);
    tick();
    check("set_wins", int'(bus.o_overflow), 1);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, i, 8, 1, 0);
      tick();
      check("d8_vld", int'(bus.o_valid), 0);
    end
    drive(0, 77, 8, 1, 0);
    tick();
    for (int j = 0; j < 6; j++) begin
      drive(1, 50 + j, 2, 1, 0);
      tick();
      check("d2_vld", int'(bus.o_valid), int'(j % 2 == 0));
      if (j % 2 == 0)
        check("d2_data", int'(bus.o_data), 50 + j);
    end

    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 30 + i, 1, 0, 0);
      tick();
    end
    drive(0, 0, 1, 1, 0);
    tick();
    check("mid_cnt", int'(bus.o_count), 3);
    check("mid_ovf", int'(bus.o_overflow), 1);
    i_reset = 1'b0;
    #1;
    zeros("mid");
    tick();
    i_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 40 + i, 3, 1, 0);
      tick();
      check("d3_vld", int'(bus.o_valid), int'(i == 2));
    end
    check("d3_data", int'(bus.o_data), 42);

    do_reset();
    dec = $urandom_range(0, 15);
    for (int c = 0; c < 4000; c++) begin
      rmode = (c / 400) % 3;
      if ($urandom_range(0, 24) == 0)
        dec = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3)
                                          : $urandom_range(0, 15);
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 255),
            dec,
            (rmode == 0) ? ($urandom_range(0, 7) == 0) :
            (rmode == 1) ? ($urandom_range(0, 1) == 0) :
                           ($urandom_range(0, 7) != 0),
            $urandom_range(0, 15) == 0);
      tick();
    end

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
